// File: rtl/insrom_pkg.sv
// Shared definitions for the instruction-ROM arbiter: default widths, port
// indices, response-slot state encoding and the address alignment helper.
package insrom_pkg;

    localparam int WORD_DEF = 32;
    localparam int ADDR_DEF = 32;

    localparam int PORT_IF = 0;
    localparam int PORT_LD = 1;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_LIVE  = 2'd1,
        SLOT_HELD  = 2'd2
    } slot_state_e;

    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/insrom_arb_port.sv
// One requester's response slot: EMPTY/LIVE/HELD state, hold register and
// eligibility. Optional error bit under INSROM_ARB_MISALIGN_CHK_EN.
module insrom_arb_port
    import insrom_pkg::*;
#(
    parameter int WORD = WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            rsp_ready_i,
    input  logic            grant_i,
`ifdef INSROM_ARB_MISALIGN_CHK_EN
    input  logic            misalign_i,
    output logic            rsp_err_o,
`endif
    input  logic [WORD-1:0] rom_dout_i,
    output logic            eligible_o,
    output logic            rsp_valid_o,
    output logic [WORD-1:0] rsp_data_o
);

    slot_state_e     state_q, state_d;
    logic [WORD-1:0] hold_q, hold_d;
    logic [WORD-1:0] live_data_s;

`ifdef INSROM_ARB_MISALIGN_CHK_EN
    logic err_q, err_d;

    // A misaligned grant never reaches the ROM, so its live word is forced to zero.
    always_comb begin
        live_data_s = err_q ? '0 : rom_dout_i;
    end

    assign rsp_err_o = rsp_valid_o & err_q;
`else
    // Live word is the ROM output in the cycle after the grant.
    always_comb begin
        live_data_s = rom_dout_i;
    end
`endif

    // Response outputs and eligibility for a new grant.
    always_comb begin
        rsp_valid_o = (state_q == SLOT_LIVE) || (state_q == SLOT_HELD);
        case (state_q)
            SLOT_LIVE: rsp_data_o = live_data_s;
            SLOT_HELD: rsp_data_o = hold_q;
            default:   rsp_data_o = '0;
        endcase
        eligible_o = req_valid_i &&
                     ((state_q == SLOT_EMPTY) || (rsp_valid_o && rsp_ready_i));
    end

    // Slot next state; a grant always wins since the old word drains the same cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef INSROM_ARB_MISALIGN_CHK_EN
        err_d   = err_q;
`endif
        if (grant_i) begin
            state_d = SLOT_LIVE;
`ifdef INSROM_ARB_MISALIGN_CHK_EN
            err_d   = misalign_i;
`endif
        end else begin
            case (state_q)
                SLOT_LIVE: begin
                    if (rsp_ready_i) begin
                        state_d = SLOT_EMPTY;
                    end else begin
                        state_d = SLOT_HELD;
                        hold_d  = live_data_s;
                    end
                end
                SLOT_HELD: begin
                    if (rsp_ready_i) begin
                        state_d = SLOT_EMPTY;
                    end else begin
                        state_d = SLOT_HELD;
                    end
                end
                default: begin
                    state_d = SLOT_EMPTY;
                end
            endcase
        end
    end

    // Slot registers; reset discards any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            hold_q  <= '0;
`ifdef INSROM_ARB_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
`ifdef INSROM_ARB_MISALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: rtl/insrom_arbiter.sv
// Round-robin sharing of the synchronous instruction ROM between fetch (port 0)
// and load (port 1). Optional misalignment check: INSROM_ARB_MISALIGN_CHK_EN.
module insrom_arbiter
    import insrom_pkg::*;
#(
    parameter int WORD = WORD_DEF,
    parameter int ADDR = ADDR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [ADDR-1:0] req_addr0,
    input  logic [ADDR-1:0] req_addr1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [WORD-1:0] rsp_data0,
    output logic [WORD-1:0] rsp_data1,
`ifdef INSROM_ARB_MISALIGN_CHK_EN
    output logic [1:0]      rsp_err,
`endif
    output logic [ADDR-1:0] rom_addr,
    input  logic [WORD-1:0] rom_dout
);

    logic [1:0] elig_s;
    logic [1:0] grant_s;
    logic [1:0] mis_s;
    logic       lg_q, lg_d;

`ifdef INSROM_ARB_MISALIGN_CHK_EN
    assign mis_s = {addr_misaligned(req_addr1[1:0]), addr_misaligned(req_addr0[1:0])};
`else
    assign mis_s = 2'b00;
`endif

    insrom_arb_port #(.WORD(WORD)) u_port_if (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid[PORT_IF]),
        .rsp_ready_i (rsp_ready[PORT_IF]),
        .grant_i     (grant_s[PORT_IF]),
`ifdef INSROM_ARB_MISALIGN_CHK_EN
        .misalign_i  (mis_s[PORT_IF]),
        .rsp_err_o   (rsp_err[PORT_IF]),
`endif
        .rom_dout_i  (rom_dout),
        .eligible_o  (elig_s[PORT_IF]),
        .rsp_valid_o (rsp_valid[PORT_IF]),
        .rsp_data_o  (rsp_data0)
    );

    insrom_arb_port #(.WORD(WORD)) u_port_ld (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid[PORT_LD]),
        .rsp_ready_i (rsp_ready[PORT_LD]),
        .grant_i     (grant_s[PORT_LD]),
`ifdef INSROM_ARB_MISALIGN_CHK_EN
        .misalign_i  (mis_s[PORT_LD]),
        .rsp_err_o   (rsp_err[PORT_LD]),
`endif
        .rom_dout_i  (rom_dout),
        .eligible_o  (elig_s[PORT_LD]),
        .rsp_valid_o (rsp_valid[PORT_LD]),
        .rsp_data_o  (rsp_data1)
    );

    // Round-robin pick; lg_q holds the index of the last granted port.
    always_comb begin
        grant_s = 2'b00;
        lg_d    = lg_q;
        if (!rst_n) begin
            grant_s = 2'b00;
        end else begin
            case (elig_s)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = lg_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
            if (grant_s != 2'b00) begin
                lg_d = grant_s[PORT_LD];
            end else begin
                lg_d = lg_q;
            end
        end
    end

    assign req_ready = grant_s;

    // ROM address follows the granted port; idle or misaligned grants drive zero.
    always_comb begin
        rom_addr = '0;
        case (grant_s)
            2'b01:   rom_addr = mis_s[PORT_IF] ? '0 : req_addr0;
            2'b10:   rom_addr = mis_s[PORT_LD] ? '0 : req_addr1;
            default: rom_addr = '0;
        endcase
    end

    // Last-grant pointer; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lg_q <= 1'b1;
        end else begin
            lg_q <= lg_d;
        end
    end

endmodule
